// File: rtl/sync_barrier_ctrl.sv
// -----------------------------------------------------------------------------
// sync_barrier_ctrl
//   Central sync-barrier responder. Collects rising-edge barrier requests from
//   the participating cores, checks that they all carry the same barrier ID,
//   and releases every participant together with a one-cycle sync_enable.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   sync_barrier_in  per-core barrier IDs, core i at [i*W +: W]
//   sync_req_in      per-core request level (rising edge = arrival)
//   cfg_mask         participant mask (sampled while idle)
//   cfg_timeout      wait-cycle limit, 0 = no timeout
//   err_clear        clears error flags, leaves the error state
//   sync_enable      release pulse to the cores
//   barrier_id_out   ID of the current / last barrier
//   arrived          arrival bitmap of the current barrier
//   busy             barrier in progress (waiting or releasing)
//   err_timeout      sticky timeout error
//   err_id_mismatch  sticky barrier-ID mismatch error
//   barrier_count    completed barriers, wraps
// -----------------------------------------------------------------------------
module sync_barrier_ctrl #(
    parameter int N_CORES            = 4,
    parameter int SYNC_BARRIER_WIDTH = 8,
    parameter int TIMEOUT_WIDTH      = 16,
    parameter int COUNT_WIDTH        = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N_CORES*SYNC_BARRIER_WIDTH-1:0] sync_barrier_in,
    input  logic [N_CORES-1:0]                    sync_req_in,
    input  logic [N_CORES-1:0]                    cfg_mask,
    input  logic [TIMEOUT_WIDTH-1:0]              cfg_timeout,
    input  logic                                  err_clear,
    output logic [N_CORES-1:0]                    sync_enable,
    output logic [SYNC_BARRIER_WIDTH-1:0]         barrier_id_out,
    output logic [N_CORES-1:0]                    arrived,
    output logic                                  busy,
    output logic                                  err_timeout,
    output logic                                  err_id_mismatch,
    output logic [COUNT_WIDTH-1:0]                barrier_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    state_t                          state_q;
    logic [N_CORES-1:0]              req_q;
    logic [N_CORES-1:0]              mask_q;
    logic [N_CORES-1:0]              arrived_q;
    logic [N_CORES-1:0]              sync_en_q;
    logic [SYNC_BARRIER_WIDTH-1:0]   bid_q;
    logic [TIMEOUT_WIDTH-1:0]        tcnt_q;
    logic [COUNT_WIDTH-1:0]          count_q;
    logic                            err_tmo_q;
    logic                            err_id_q;

    logic [SYNC_BARRIER_WIDTH-1:0]   core_id [N_CORES];
    logic [N_CORES-1:0]              rise;
    logic [N_CORES-1:0]              mask_eff;
    logic [N_CORES-1:0]              valid_rise;
    logic [N_CORES-1:0]              new_rise;
    logic [SYNC_BARRIER_WIDTH-1:0]   first_id;
    logic                            idle_mismatch;
    logic                            wait_mismatch;
    logic                            wait_done;
    logic                            tmo_hit;

    genvar g;
    generate
        for (g = 0; g < N_CORES; g++) begin : g_id
            assign core_id[g] = sync_barrier_in[g*SYNC_BARRIER_WIDTH +: SYNC_BARRIER_WIDTH];
        end
    endgenerate

    // While idle the mask register is being reloaded every cycle, so the
    // live cfg_mask is the mask that applies to an arrival in that cycle (and
    // is exactly what gets frozen into mask_q on the same edge). This also
    // lets a request that is already high out of reset count as an arrival.
    assign rise       = sync_req_in & ~req_q;
    assign mask_eff   = (state_q == S_IDLE) ? cfg_mask : mask_q;
    assign valid_rise = rise & mask_eff;
    // Repeat rises from cores that already arrived carry no information.
    assign new_rise   = valid_rise & ~arrived_q;
    assign wait_done  = ((arrived_q | valid_rise) == mask_q);
    assign tmo_hit    = (cfg_timeout != '0) &&
                        (tcnt_q == cfg_timeout - TIMEOUT_WIDTH'(1));

    always_comb begin
        // ID of the lowest-index valid riser names the barrier.
        first_id = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (valid_rise[i]) first_id = core_id[i];
        end
        idle_mismatch = 1'b0;
        wait_mismatch = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            if (valid_rise[i] && core_id[i] != first_id) idle_mismatch = 1'b1;
            if (new_rise[i] && core_id[i] != bid_q)      wait_mismatch = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            mask_q    <= '0;
            arrived_q <= '0;
            sync_en_q <= '0;
            bid_q     <= '0;
            tcnt_q    <= '0;
            count_q   <= '0;
            err_tmo_q <= 1'b0;
            err_id_q  <= 1'b0;
        end else begin
            req_q     <= sync_req_in;
            sync_en_q <= '0;
            // A flag set in the same cycle below takes precedence over the clear.
            if (err_clear) begin
                err_tmo_q <= 1'b0;
                err_id_q  <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    mask_q <= cfg_mask;
                    if (valid_rise != '0) begin
                        bid_q     <= first_id;
                        arrived_q <= valid_rise;
                        tcnt_q    <= '0;
                        if (idle_mismatch) begin
                            err_id_q <= 1'b1;
                            state_q  <= S_ERROR;
                        end else if (valid_rise == cfg_mask) begin
                            sync_en_q <= cfg_mask;
                            state_q   <= S_RELEASE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    arrived_q <= arrived_q | valid_rise;
                    if (tcnt_q != '1) tcnt_q <= tcnt_q + TIMEOUT_WIDTH'(1);
                    // Priority: mismatch, then completion, then timeout.
                    if (wait_mismatch) begin
                        err_id_q <= 1'b1;
                        state_q  <= S_ERROR;
                    end else if (wait_done) begin
                        sync_en_q <= mask_q;
                        state_q   <= S_RELEASE;
                    end else if (tmo_hit) begin
                        err_tmo_q <= 1'b1;
                        state_q   <= S_ERROR;
                    end
                end
                S_RELEASE: begin
                    count_q   <= count_q + COUNT_WIDTH'(1);
                    arrived_q <= '0;
                    state_q   <= S_IDLE;
                end
                S_ERROR: begin
                    // arrived / barrier ID are held for debug until cleared.
                    if (err_clear) begin
                        arrived_q <= '0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sync_enable     = sync_en_q;
    assign barrier_id_out  = bid_q;
    assign arrived         = arrived_q;
    assign busy            = (state_q == S_WAIT) || (state_q == S_RELEASE);
    assign err_timeout     = err_tmo_q;
    assign err_id_mismatch = err_id_q;
    assign barrier_count   = count_q;

endmodule

// File: tb/tb_sync_barrier_ctrl.sv
module tb_sync_barrier_ctrl;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TW = 16;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*W-1:0]  sbi;
    logic [N-1:0]    req, mask;
    logic [TW-1:0]   tmo;
    logic            clr;
    logic [N-1:0]    sync_enable, arrived;
    logic [W-1:0]    barrier_id_out;
    logic            busy, err_timeout, err_id_mismatch;
    logic [CW-1:0]   barrier_count;

    int checks = 0;
    int failures = 0;

    sync_barrier_ctrl #(.N_CORES(N), .SYNC_BARRIER_WIDTH(W),
                        .TIMEOUT_WIDTH(TW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .sync_barrier_in(sbi), .sync_req_in(req),
        .cfg_mask(mask), .cfg_timeout(tmo), .err_clear(clr),
        .sync_enable(sync_enable), .barrier_id_out(barrier_id_out),
        .arrived(arrived), .busy(busy), .err_timeout(err_timeout),
        .err_id_mismatch(err_id_mismatch), .barrier_count(barrier_count));

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // A barrier is "open" while cores are still expected, "releasing" for the
    // single cycle after the last one arrives, "failed" after an error.
    bit        m_open, m_releasing, m_failed;
    int        m_arrivals[$];      // core indices in arrival order
    logic [N-1:0] m_mask, m_prev, m_sync;
    logic [W-1:0] m_bid;
    int        m_waited, m_count;
    bit        m_ftmo, m_fid;

    function automatic logic [W-1:0] id_of(int i);
        logic [N*W-1:0] v;
        v = sbi;
        return v[i*W +: W];
    endfunction

    function automatic logic [N-1:0] m_arrived();
        logic [N-1:0] b;
        b = '0;
        foreach (m_arrivals[k]) b[m_arrivals[k]] = 1'b1;
        return b;
    endfunction

    function automatic bit has_arrived(int i);
        foreach (m_arrivals[k]) if (m_arrivals[k] == i) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int members(logic [N-1:0] m);
        int n;
        n = 0;
        for (int i = 0; i < N; i++) if (m[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_open = 0; m_releasing = 0; m_failed = 0;
        m_arrivals.delete();
        m_mask = '0; m_prev = '0; m_sync = '0; m_bid = '0;
        m_waited = 0; m_count = 0; m_ftmo = 0; m_fid = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] rise;
        bit mis;
        int first;
        rise   = req & ~m_prev;
        m_prev = req;
        m_sync = '0;
        mis    = 0;
        if (clr) begin m_ftmo = 0; m_fid = 0; end
        if (m_releasing) begin
            m_count = (m_count + 1) % (1 << CW);
            m_arrivals.delete();
            m_releasing = 0;
        end else if (m_failed) begin
            if (clr) begin m_arrivals.delete(); m_failed = 0; end
        end else if (m_open) begin
            for (int i = 0; i < N; i++)
                if (m_mask[i] && rise[i] && !has_arrived(i)) begin
                    if (id_of(i) != m_bid) mis = 1;
                    m_arrivals.push_back(i);
                end
            if (mis) begin
                m_open = 0; m_failed = 1; m_fid = 1;
            end else if (m_arrivals.size() == members(m_mask)) begin
                m_open = 0; m_releasing = 1; m_sync = m_mask;
            end else if (tmo != 0 && m_waited == int'(tmo) - 1) begin
                m_open = 0; m_failed = 1; m_ftmo = 1;
            end
            if (m_waited < (1 << TW) - 1) m_waited++;
        end else begin
            m_mask = mask;
            first = -1;
            for (int i = 0; i < N; i++)
                if (mask[i] && rise[i]) begin
                    if (first < 0) first = i;
                    m_arrivals.push_back(i);
                end
            if (first >= 0) begin
                m_bid = id_of(first);
                m_waited = 0;
                foreach (m_arrivals[k]) if (id_of(m_arrivals[k]) != m_bid) mis = 1;
                if (mis) begin
                    m_failed = 1; m_fid = 1;
                end else if (m_arrivals.size() == members(mask)) begin
                    m_releasing = 1; m_sync = mask;
                end else begin
                    m_open = 1;
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("sync_enable",   32'(sync_enable),     32'(m_sync));
        chk("barrier_id",    32'(barrier_id_out),  32'(m_bid));
        chk("arrived",       32'(arrived),         32'(m_arrived()));
        chk("busy",          32'(busy),            32'(m_open || m_releasing));
        chk("err_timeout",   32'(err_timeout),     32'(m_ftmo));
        chk("err_mismatch",  32'(err_id_mismatch), 32'(m_fid));
        chk("barrier_count", 32'(barrier_count),   32'(m_count));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic set_ids(logic [W-1:0] a, logic [W-1:0] b,
                           logic [W-1:0] c, logic [W-1:0] d);
        sbi = {d, c, b, a};
    endtask

    // ---------------- table for the basic release ----------------
    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  sync;
        logic          busy;
        logic [N-1:0]  arr;
        logic [CW-1:0] cnt;
    } tvec_t;

    tvec_t t1[10];
    int pulses;

    initial begin
        t1[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 16'd0};
        t1[1] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 16'd0};
        t1[2] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 16'd0};
        t1[3] = '{4'b0101, 4'b0000, 1'b1, 4'b0101, 16'd0};
        t1[4] = '{4'b0111, 4'b0000, 1'b1, 4'b0111, 16'd0};
        t1[5] = '{4'b0111, 4'b0000, 1'b1, 4'b0111, 16'd0};
        t1[6] = '{4'b0111, 4'b0000, 1'b1, 4'b0111, 16'd0};
        t1[7] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 16'd0};
        t1[8] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 16'd1};
        t1[9] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 16'd1};

        reset = 1'b0; req = '0; mask = '0; tmo = '0; clr = 1'b0;
        set_ids(8'h05, 8'h05, 8'h05, 8'h05);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sync",  32'(sync_enable),   32'h0);
        chk("reset_busy",  32'(busy),          32'h0);
        chk("reset_count", 32'(barrier_count), 32'h0);
        chk("reset_arr",   32'(arrived),       32'h0);
        reset = 1'b1;
        mask = 4'b1111;
        step();

        // 1. basic release, table driven
        for (int k = 0; k < 10; k++) begin
            req = t1[k].req;
            step();
            chk("t1_sync",  32'(sync_enable),   32'(t1[k].sync));
            chk("t1_busy",  32'(busy),          32'(t1[k].busy));
            chk("t1_arr",   32'(arrived),       32'(t1[k].arr));
            chk("t1_count", 32'(barrier_count), 32'(t1[k].cnt));
        end

        // 2. partial mask, simultaneous arrival, unmasked core toggling
        mask = 4'b0101; set_ids(8'h3A, 8'h77, 8'h3A, 8'h3A);
        req = 4'b0010; step();
        chk("t2_ignored", 32'(busy), 32'h0);
        req = 4'b0000; step();
        req = 4'b0111; step();
        chk("t2_sync", 32'(sync_enable), 32'h5);
        req = 4'b0101; step();
        req = 4'b0000; step();

        // 3. ID mismatch
        mask = 4'b0011; set_ids(8'h01, 8'h02, 8'h00, 8'h00);
        req = 4'b0001; step();
        req = 4'b0011; step();
        chk("t3_mismatch", 32'(err_id_mismatch), 32'h1);
        chk("t3_bid",      32'(barrier_id_out),  32'h01);
        step(); step();
        chk("t3_no_sync",  32'(sync_enable),     32'h0);
        clr = 1'b1; step(); clr = 1'b0;
        chk("t3_cleared",  32'(err_id_mismatch), 32'h0);
        req = 4'b0000; step();

        // 4. timeout, then timeout disabled
        tmo = 16'd10; set_ids(8'h05, 8'h05, 8'h05, 8'h05);
        req = 4'b0001; step();
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9)  chk("t4_tmo_early", 32'(err_timeout), 32'h0);
            if (k == 10) chk("t4_tmo",       32'(err_timeout), 32'h1);
        end
        clr = 1'b1; step(); clr = 1'b0;
        req = 4'b0000; step();
        tmo = 16'd0;
        req = 4'b0001; step();
        repeat (1000) step();
        chk("t4_still_wait", 32'(busy), 32'h1);
        req = 4'b0011; step();
        chk("t4_release", 32'(sync_enable), 32'h3);
        step();
        req = 4'b0000; step();

        // 5. level-held requests, back-to-back barriers
        pulses = 0;
        req = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req = 4'b0000;
            step();
            if (sync_enable != 0) pulses++;
        end
        set_ids(8'h06, 8'h06, 8'h06, 8'h06);
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) req = 4'b0000;
            step();
            if (sync_enable != 0) pulses++;
        end
        chk("t5_pulses", 32'(pulses), 32'd2);
        chk("t5_count",  32'(barrier_count), 32'd5);
        chk("t5_bid",    32'(barrier_id_out), 32'h06);

        // 6. asynchronous reset mid-WAIT
        set_ids(8'h07, 8'h07, 8'h07, 8'h07);
        req = 4'b0001; step();
        chk("t6_arr", 32'(arrived), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_arr",   32'(arrived),       32'h0);
        chk("t6_rst_busy",  32'(busy),          32'h0);
        chk("t6_rst_count", 32'(barrier_count), 32'h0);
        chk("t6_rst_bid",   32'(barrier_id_out),32'h0);
        model_reset();
        #2 reset = 1'b1;
        step();
        chk("t6_held_req", 32'(arrived), 32'h1);
        req = 4'b0011; step();
        chk("t6_sync", 32'(sync_enable), 32'h3);
        step();
        chk("t6_count", 32'(barrier_count), 32'h1);
        req = 4'b0000; step();

        // random stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(49) == 0) mask = 4'($urandom);
            if ($urandom_range(99) == 0) begin
                case ($urandom_range(3))
                    0: tmo = 16'd0;
                    1: tmo = 16'd1;
                    2: tmo = 16'd4;
                    default: tmo = 16'd20;
                endcase
            end
            if ($urandom_range(29) == 0)
                set_ids(8'h10 + 8'($urandom_range(1)), 8'h10 + 8'($urandom_range(1)),
                        8'h10 + 8'($urandom_range(1)), 8'h10 + 8'($urandom_range(1)));
            else if ($urandom_range(29) == 0)
                set_ids(8'h10, 8'h10, 8'h10, 8'h10);
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0) req[i] = ~req[i];
            clr = ($urandom_range(19) == 0);
            step();
        end
        clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
